// File: rtl/exp7_unidade_controle.sv
// Moore control unit for the growing-sequence memory game (exp7).
// Define EXP7_UC_TIMEOUT_EN to enable the play-timeout path (state fim_timeout, contaT, timeout).
module exp7_unidade_controle (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       fimE,
    input  logic       fimL,
    input  logic       jogada,
    input  logic       igual,
    input  logic       fimT,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h7,
`ifdef EXP7_UC_TIMEOUT_EN
        FIM_TIMEOUT    = 4'hD,
`endif
        FIM_ACERTOU    = 4'hA,
        FIM_ERROU      = 4'hE
    } state_t;

    // Output vector bit positions, shared by the decoder and the port mapping.
    localparam int O_ZERAE     = 11;
    localparam int O_CONTAE    = 10;
    localparam int O_ZERAL     = 9;
    localparam int O_CONTAL    = 8;
    localparam int O_ZERAR     = 7;
    localparam int O_REGISTRAR = 6;
    localparam int O_ZERAT     = 5;
    localparam int O_CONTAT    = 4;
    localparam int O_ACERTOU   = 3;
    localparam int O_ERROU     = 2;
    localparam int O_TIMEOUT   = 1;
    localparam int O_PRONTO    = 0;

    state_t      r_state;
    logic [11:0] r_out;
    state_t      w_next;

    function automatic state_t f_next(
        input state_t s,
        input logic   ini,
        input logic   fe,
        input logic   fl,
        input logic   jg,
        input logic   ig,
        input logic   ft
    );
        state_t n;
        n = INICIAL;
        case (s)
            INICIAL:        n = ini ? PREPARACAO : INICIAL;
            PREPARACAO:     n = INICIO_RODADA;
            INICIO_RODADA:  n = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // A play in the same cycle as expiry still counts.
                if (jg)
                    n = REGISTRA;
`ifdef EXP7_UC_TIMEOUT_EN
                else if (ft)
                    n = FIM_TIMEOUT;
`endif
                else
                    n = ESPERA_JOGADA;
            end
            REGISTRA:       n = COMPARACAO;
            COMPARACAO: begin
                if (!ig)
                    n = FIM_ERROU;
                else if (!fe)
                    n = PROXIMO;
                else if (!fl)
                    n = PROXIMA_RODADA;
                else
                    n = FIM_ACERTOU;
            end
            PROXIMO:        n = ESPERA_JOGADA;
            PROXIMA_RODADA: n = INICIO_RODADA;
            FIM_ACERTOU:    n = ini ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:      n = ini ? PREPARACAO : FIM_ERROU;
`ifdef EXP7_UC_TIMEOUT_EN
            FIM_TIMEOUT:    n = ini ? PREPARACAO : FIM_TIMEOUT;
`endif
            default:        n = INICIAL;
        endcase
`ifndef EXP7_UC_TIMEOUT_EN
        if (ft && 1'b0)
            n = INICIAL;
`endif
        return n;
    endfunction

    function automatic logic [11:0] f_decode(input state_t s);
        logic [11:0] o;
        o = '0;
        case (s)
            PREPARACAO: begin
                o[O_ZERAE] = 1'b1;
                o[O_ZERAL] = 1'b1;
                o[O_ZERAR] = 1'b1;
                o[O_ZERAT] = 1'b1;
            end
            INICIO_RODADA: begin
                o[O_ZERAE] = 1'b1;
                o[O_ZERAT] = 1'b1;
            end
            ESPERA_JOGADA: begin
`ifdef EXP7_UC_TIMEOUT_EN
                o[O_CONTAT] = 1'b1;
`endif
            end
            REGISTRA: begin
                o[O_REGISTRAR] = 1'b1;
                o[O_ZERAT]     = 1'b1;
            end
            PROXIMO:        o[O_CONTAE] = 1'b1;
            PROXIMA_RODADA: o[O_CONTAL] = 1'b1;
            FIM_ACERTOU: begin
                o[O_ACERTOU] = 1'b1;
                o[O_PRONTO]  = 1'b1;
            end
            FIM_ERROU: begin
                o[O_ERROU]  = 1'b1;
                o[O_PRONTO] = 1'b1;
            end
`ifdef EXP7_UC_TIMEOUT_EN
            FIM_TIMEOUT: begin
                o[O_TIMEOUT] = 1'b1;
                o[O_ERROU]   = 1'b1;
                o[O_PRONTO]  = 1'b1;
            end
`endif
            default:        o = '0;
        endcase
        return o;
    endfunction

    assign w_next = f_next(r_state, iniciar, fimE, fimL, jogada, igual, fimT);

    // Outputs are registered together with the state so they are always decode(r_state).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= INICIAL;
            r_out   <= '0;
        end else begin
            r_state <= w_next;
            r_out   <= f_decode(w_next);
        end
    end

    assign zeraE     = r_out[O_ZERAE];
    assign contaE    = r_out[O_CONTAE];
    assign zeraL     = r_out[O_ZERAL];
    assign contaL    = r_out[O_CONTAL];
    assign zeraR     = r_out[O_ZERAR];
    assign registraR = r_out[O_REGISTRAR];
    assign zeraT     = r_out[O_ZERAT];
    assign contaT    = r_out[O_CONTAT];
    assign acertou   = r_out[O_ACERTOU];
    assign errou     = r_out[O_ERROU];
    assign timeout   = r_out[O_TIMEOUT];
    assign pronto    = r_out[O_PRONTO];
    assign db_estado = r_state;

endmodule

// File: tb/tb_exp7_unidade_controle.sv
// Scoreboard bench for exp7_unidade_controle: expected state/output vectors are queued as
// stimulus is driven and compared one clock later. Timeout scenarios follow EXP7_UC_TIMEOUT_EN.
module tb_exp7_unidade_controle;

    logic       clock = 1'b0;
    logic       reset;
    logic       iniciar, fimE, fimL, jogada, igual, fimT;
    logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT;
    logic       acertou, errou, timeout, pronto;
    logic [3:0] db_estado;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit       ini, fe, fl, jg, ig, ft;
        bit [3:0] st;
    } step_t;

    logic [15:0] sb_q[$];

    exp7_unidade_controle dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .fimE(fimE), .fimL(fimL),
        .jogada(jogada), .igual(igual), .fimT(fimT),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .zeraT(zeraT), .contaT(contaT),
        .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic step_t mk(bit ini, bit fe, bit fl, bit jg, bit ig, bit ft, bit [3:0] st);
        step_t s;
        s.ini = ini; s.fe = fe; s.fl = fl; s.jg = jg; s.ig = ig; s.ft = ft; s.st = st;
        return s;
    endfunction

    // Expected {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
    // acertou, errou, timeout, pronto} for a given state code.
    function automatic logic [15:0] expect_vec(input logic [3:0] st);
        logic [11:0] o;
        case (st)
            4'h1: o = 12'b1010_1010_0000;
            4'h2: o = 12'b1000_0010_0000;
`ifdef EXP7_UC_TIMEOUT_EN
            4'h3: o = 12'b0000_0001_0000;
            4'hD: o = 12'b0000_0000_0111;
`else
            4'h3: o = 12'b0000_0000_0000;
`endif
            4'h4: o = 12'b0000_0110_0000;
            4'h6: o = 12'b0100_0000_0000;
            4'h7: o = 12'b0001_0000_0000;
            4'hA: o = 12'b0000_0000_1001;
            4'hE: o = 12'b0000_0000_0101;
            default: o = 12'b0;
        endcase
        return {st, o};
    endfunction

    function automatic logic [15:0] observed();
        return {db_estado, zeraE, contaE, zeraL, contaL, zeraR, registraR, zeraT, contaT,
                acertou, errou, timeout, pronto};
    endfunction

    task automatic drive(input step_t s);
        iniciar = s.ini; fimE = s.fe; fimL = s.fl; jogada = s.jg; igual = s.ig; fimT = s.ft;
    endtask

    task automatic test_reset();
        logic [15:0] got, e;
        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clock);
        #1;
        sb_q.push_back(expect_vec(4'h0));
        got = observed(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", got, e);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        sb_q.push_back(expect_vec(4'h0));
        got = observed(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_idle: got %h expected %h", got, e);
        end
    endtask

    task automatic test_start();
        step_t steps[$];
        logic [15:0] got, e;
        steps.push_back(mk(0, 1, 1, 1, 1, 1, 4'h0));
        steps.push_back(mk(1, 0, 0, 0, 0, 0, 4'h1));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb_q.push_back(expect_vec(steps[i].st));
            @(posedge clock); #1;
            got = observed(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL start step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_round0();
        step_t steps[$];
        logic [15:0] got, e;
        steps.push_back(mk(0, 0, 0, 1, 0, 0, 4'h4));
        steps.push_back(mk(1, 0, 0, 0, 0, 0, 4'h5));
        steps.push_back(mk(0, 1, 0, 0, 1, 0, 4'h7));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb_q.push_back(expect_vec(steps[i].st));
            @(posedge clock); #1;
            got = observed(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL round0 step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_midround_win();
        step_t steps[$];
        logic [15:0] got, e;
        steps.push_back(mk(0, 0, 0, 1, 0, 0, 4'h4));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5));
        steps.push_back(mk(0, 0, 1, 0, 1, 0, 4'h6));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
        steps.push_back(mk(0, 0, 0, 1, 0, 0, 4'h4));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5));
        steps.push_back(mk(0, 1, 1, 0, 1, 0, 4'hA));
        for (int k = 0; k < 10; k++)
            steps.push_back(mk(0, 1, 1, 1, 0, 1, 4'hA));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb_q.push_back(expect_vec(steps[i].st));
            @(posedge clock); #1;
            got = observed(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL midround_win step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_priority_error();
        step_t steps[$];
        logic [15:0] got, e;
        steps.push_back(mk(1, 0, 0, 0, 0, 0, 4'h1));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
        steps.push_back(mk(0, 0, 0, 1, 0, 1, 4'h4));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5));
        steps.push_back(mk(0, 1, 1, 0, 0, 0, 4'hE));
        steps.push_back(mk(0, 0, 0, 1, 1, 1, 4'hE));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'hE));
        foreach (steps[i]) begin
            drive(steps[i]);
            sb_q.push_back(expect_vec(steps[i].st));
            @(posedge clock); #1;
            got = observed(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL priority_error step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    task automatic test_timeout();
        step_t steps[$];
        logic [15:0] got, e;
        steps.push_back(mk(1, 0, 0, 0, 0, 0, 4'h1));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
`ifdef EXP7_UC_TIMEOUT_EN
        steps.push_back(mk(0, 0, 0, 0, 0, 1, 4'hD));
        steps.push_back(mk(0, 0, 0, 1, 0, 0, 4'hD));
        steps.push_back(mk(1, 0, 0, 0, 0, 0, 4'h1));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2));
        steps.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3));
`else
        for (int k = 0; k < 20; k++)
            steps.push_back(mk(0, 0, 0, 0, 0, 1, 4'h3));
`endif
        foreach (steps[i]) begin
            drive(steps[i]);
            sb_q.push_back(expect_vec(steps[i].st));
            @(posedge clock); #1;
            got = observed(); e = sb_q.pop_front(); vectors++;
            if (got !== e) begin
                miscompares++;
                $display("FAIL timeout step %0d: got %h expected %h", i, got, e);
            end
        end
    endtask

    // Asynchronous reset while waiting for a play: outputs must clear before the next edge.
    task automatic test_reset_midround();
        logic [15:0] got, e;
        drive(mk(0, 0, 0, 0, 0, 0, 0));
        #2;
        reset = 1'b1;
        #1;
        sb_q.push_back(expect_vec(4'h0));
        got = observed(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL reset_async: got %h expected %h", got, e);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(mk(1, 0, 0, 0, 0, 0, 0));
        sb_q.push_back(expect_vec(4'h1));
        @(posedge clock); #1;
        got = observed(); e = sb_q.pop_front(); vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL restart_after_reset: got %h expected %h", got, e);
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_round0();
        test_midround_win();
        test_priority_error();
        test_timeout();
        test_reset_midround();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/exp7_unidade_controle.md
Name: exp7_unidade_controle

Overview:
- Moore FSM that sequences the memory-game datapath for the growing-sequence game.
- Each round replays the stored sequence from address 0 up to a round limit. The player must match every entry before the limit grows by one.
- Drives the datapath's address counter (E), limit counter (L), play register (R) and timeout counter (T).
- Reports win, loss and timeout to the top level, and exports its state code for the HEX5 display.

Parameters:
- (none): all widths and limits live in the datapath; this block consumes only 1-bit flags.

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high; forces state inicial
iniciar  input  1  start/restart request, level-sampled
fimE  input  1  address counter equals current round limit
fimL  input  1  round limit counter at its final value (last round)
jogada  input  1  one-cycle pulse: a play was made on the switches
igual  input  1  registered play equals memory at current address
fimT  input  1  timeout counter expired
zeraE  output  1  clear address counter
contaE  output  1  increment address counter
zeraL  output  1  clear round-limit counter
contaL  output  1  increment round-limit counter
zeraR  output  1  clear play register
registraR  output  1  load play register
zeraT  output  1  clear timeout counter
contaT  output  1  enable timeout counter
acertou  output  1  game won
errou  output  1  game lost (wrong play or timeout)
timeout  output  1  loss caused by timeout
pronto  output  1  game finished
db_estado  output  4  current state code

Behaviour:
- Pure Moore machine: outputs are decoded from the state register only; all unlisted outputs are 0.
- reset (async, any time, including mid-round): state = inicial (0x0); every output is 0 and db_estado = 0.
- States, codes, asserted outputs and transitions:
  - inicial 0x0: no outputs. iniciar=1 → preparacao, else stay.
  - preparacao 0x1: zeraE, zeraL, zeraR, zeraT. → inicio_rodada.
  - inicio_rodada 0x2: zeraE, zeraT. → espera_jogada.
  - espera_jogada 0x3: contaT.
    - jogada=1 → registra.
    - jogada=0 and fimT=1 → fim_timeout.
    - Otherwise stay.
    - jogada has priority over fimT in the same cycle.
  - registra 0x4: registraR, zeraT. → comparacao.
  - comparacao 0x5:
    - igual=0 → fim_errou.
    - igual=1, fimE=0 → proximo.
    - igual=1, fimE=1, fimL=0 → proxima_rodada.
    - igual=1, fimE=1, fimL=1 → fim_acertou.
  - proximo 0x6: contaE. → espera_jogada.
  - proxima_rodada 0x7: contaL. → inicio_rodada.
  - fim_acertou 0xA: acertou, pronto.
  - fim_errou 0xE: errou, pronto.
  - fim_timeout 0xD: timeout, errou, pronto.
- Terminal states (0xA, 0xE, 0xD): iniciar=1 → preparacao (new game without reset); else hold. Outputs stay at level until then.
- Latency from a jogada pulse to the verdict: registra, then comparacao, then the result state = 3 clocks.
- Round k (limit k) takes k+1 correct plays. The controller has no knowledge of memory depth; it relies on fimL.
- fimE, fimL, igual are sampled only in comparacao. jogada and fimT are sampled only in espera_jogada. iniciar is sampled only in inicial and terminal states.
- Unused state codes → inicial on the next clock.

Optional Feature:
- Macro: EXP7_UC_TIMEOUT_EN.
- Defined: timeout logic exactly as above.
- Undefined:
  - fimT is ignored and state fim_timeout does not exist.
  - contaT is tied 0; zeraT is still asserted.
  - timeout is tied 0.
  - espera_jogada waits indefinitely for jogada.

Test Plan:
- reset pulse mid-espera_jogada → db_estado=0 and all outputs 0 on the same cycle, before the next clock edge.
- iniciar=1 for 1 clock from inicial → db_estado 1 (zeraE/zeraL/zeraR/zeraT=1), then 2, then 3 with contaT=1.
- Round 0 with fimE=1, fimL=0: jogada pulse, igual=1 → states 4, 5, 7 (contaL=1), 2, 3.
- Mid-round with fimE=0, igual=1 → 4, 5, 6 (contaE=1), back to 3. Next play with fimE=1, fimL=1, igual=1 → 0xA, acertou=1, pronto=1, held for 10 clocks.
- In state 3, jogada=1 and fimT=1 in the same cycle → next state 4, not 0xD. Then igual=0 → 0xE, errou=1, timeout=0.
- In state 3, fimT=1 alone → 0xD, timeout=errou=pronto=1. Then iniciar=1 → state 1. With EXP7_UC_TIMEOUT_EN undefined, fimT=1 for 20 clocks → stays 3 and contaT=0.
